bcd_serial_accum: RTL and testbench
===================================

// Module: bcd_serial_accum
// PURPOSE
//  Digit-serial multi-digit BCD adder. Captures two packed DIGITS-digit BCD operands
//  and a carry-in on a valid/ready handshake. Walks the digits LSD first, one per clock,
//  through a single 4-bit BCD digit add with decimal correction, keeping the decimal
//  carry in a flop between digits. Presents the packed BCD sum and carry-out on an
//  output valid/ready handshake. Sits directly upstream of, and sequences, the
//  combinational one-digit BCD adder.
// PARAMETERS
//  DIGITS  4  number of BCD digits per operand (>=1); operand/sum width = 4*DIGITS
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         a/b/cin valid
//  in_ready   out  1         block can accept operands (high only in IDLE)
//  a          in   4*DIGITS  operand A, packed BCD, digit 0 = a[3:0]
//  b          in   4*DIGITS  operand B, packed BCD
//  cin        in   1         decimal carry into digit 0
//  out_valid  out  1         sum/cout valid
//  out_ready  in   1         consumer accepts result
//  sum        out  4*DIGITS  packed BCD result
//  cout       out  1         decimal carry out of MSD
//  busy       out  1         high in RUN
//  err        out  1         non-BCD operand digit seen (BCD_DIGIT_CHECK_EN only)
// BEHAVIOUR
//  - Clock clk; reset rst is synchronous and active-high. rst=1 at a rising edge: state=IDLE,
//    in_ready=1, out_valid=0, busy=0, sum=0, cout=0, err=0, digit index=0, carry flop=0.
//  - rst dominates every other input. rst mid-RUN or in DONE drops the transaction
//    without output.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. At an edge with in_valid=1:
//      - latch a, b, cin (carry flop <= cin);
//      - clear index and sum;
//      - go to RUN.
//  - RUN: in_ready=0, busy=1. Each edge processes digit i = index:
//      - z = a_i + b_i + c (5-bit);
//      - K = z[4] | (z[3]&z[2]) | (z[3]&z[1]);
//      - sum_i <= K ? (z+6)[3:0] : z[3:0];
//      - c <= K; index++.
//      - At the edge processing i=DIGITS-1: cout <= K, go to DONE.
//  - DONE: out_valid=1. sum and cout are stable. At an edge with out_ready=1, go to IDLE.
//    out_valid stays high until accepted (out_ready may be held high in advance).
//  - Latency: accept at edge k. Digit i is written at edge k+1+i. out_valid is high from
//    the cycle after edge k+DIGITS. Min accept-to-accept period = DIGITS+2 cycles
//    (in_ready is low in DONE, no DONE->RUN bypass).
//  - in_valid outside IDLE is ignored. Operands need not be held after acceptance.
//  - sum and cout hold their last value after out_valid falls, until the next accept
//    clears sum.
//  - Non-BCD digits (>9) follow the same correction rule. The result is undefined
//    decimally but deterministic.
// CONFIGURATION
//  - BCD_DIGIT_CHECK_EN defined:
//      - at accept, err <= 1 if any nibble of a or b > 9, else 0;
//      - err holds until the next accept or rst.
//  - BCD_DIGIT_CHECK_EN undefined: err tied to 0. No check logic.
//  - Arithmetic and timing are identical in both builds.
// TESTING (DIGITS=4)
//  1. a=16'h1234, b=16'h5678, cin=0 -> after 5 cycles out_valid, sum=16'h6912, cout=0.
//  2. a=16'h9999, b=16'h0000, cin=1 -> sum=16'h0000, cout=1. Carry ripples through all
//     digits.
//  3. a=16'h0505, b=16'h0505, cin=0, out_ready=0 for 10 cycles -> sum=16'h1010 held,
//     out_valid high, in_ready low, a 2nd in_valid ignored. Then out_ready=1 -> IDLE
//     next cycle.
//  4. rst asserted at RUN digit 2 -> next cycle in_ready=1, out_valid=0, sum=0, cout=0.
//     A new 0001+0001 then yields 16'h0002.
//  5. Back-to-back accepts with out_ready=1 -> in_ready pulses exactly every 6 cycles.
//     Sums are correct per transaction.
//  6. BCD_DIGIT_CHECK_EN: a=16'h00A0, b=0 -> err=1. Then a=16'h0001 -> err=0.
//     Without the macro, err stays 0 throughout.

Source files
------------

// File: rtl/bcd_serial_accum.sv
// bcd_serial_accum: digit-serial multi-digit BCD adder.
// Operands are captured on an in_valid/in_ready handshake and walked LSD first,
// one digit per clock, through a single decimal-corrected 4-bit digit adder.
// The packed result is presented on an out_valid/out_ready handshake.
// Optional build macro: BCD_DIGIT_CHECK_EN flags non-BCD operand nibbles on err.
module bcd_serial_accum #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                busy,
    output logic                err
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;

    logic [3:0]      a_dig;
    logic [3:0]      b_dig;
    logic [4:0]      z;
    logic            k;
    logic [3:0]      dig_sum;

    logic            accept;
    logic            last_dig;

    assign accept   = (state_q == IDLE) && in_valid;
    assign last_dig = (idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_dig)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == RUN);
        out_valid = (state_q == DONE);
    end

    // One-digit BCD add with decimal correction on the digit selected by idx_q
    always_comb begin
        a_dig   = a_q[{idx_q, 2'b00} +: 4];
        b_dig   = b_q[{idx_q, 2'b00} +: 4];
        z       = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
        k       = z[4] | (z[3] & z[2]) | (z[3] & z[1]);
        dig_sum = k ? (z[3:0] + 4'd6) : z[3:0];
    end

    // Datapath next-state: capture at accept, write one sum digit per RUN cycle
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            RUN: begin
                sum_d[{idx_q, 2'b00} +: 4] = dig_sum;
                carry_d = k;
                idx_d   = idx_q + 1'b1;
                if (last_dig) begin
                    cout_d = k;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef BCD_DIGIT_CHECK_EN
    logic err_q, err_d;
    logic bad_nibble;

    // Flag any operand nibble above 9 on the inputs being offered
    always_comb begin
        bad_nibble = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                bad_nibble = 1'b1;
            end
        end
        err_d = accept ? bad_nibble : err_q;
    end

    // err is sampled at accept and held until the next accept or reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_accum.sv
// Scoreboard bench for bcd_serial_accum (DIGITS=4): directed cases plus random
// BCD traffic checked against a decimal-arithmetic reference model.
module tb_bcd_serial_accum;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         err;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   rnd_ready = 1'b0;

    bcd_serial_accum #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: plain decimal arithmetic on the operand values
    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] r = '0;
        longint t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic nonbcd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic r = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t e;
        longint lim = 1;
        longint s;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        s = bcd2int(x) + bcd2int(y) + longint'(c);
        e.sum  = int2bcd(s % lim);
        e.cout = (s >= lim);
`ifdef BCD_DIGIT_CHECK_EN
        e.err  = nonbcd(x, y);
`else
        e.err  = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Monitor: pops expected results at each output handshake
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum",  64'(sum),  64'(e.sum));
                check("cout", 64'(cout), 64'(e.cout));
                check("err",  64'(err),  64'(e.err));
            end
        end
    end

    // Random back-pressure driver
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200 && !in_ready; i++) step();
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    // Offer one transaction; returns one cycle after the accept edge
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input bit push, input bit use_ovr, input exp_t ovr);
        wait_ready();
        a = x;
        b = y;
        cin = c;
        in_valid = 1'b1;
        if (push) sb.push_back(use_ovr ? ovr : model(x, y, c));
        step();
        in_valid = 1'b0;
        a = rand_bcd();
        b = rand_bcd();
    endtask

    initial begin
        exp_t none;
        exp_t ovr;
        int   last_acc;
        none.sum = '0; none.cout = 1'b0; none.err = 1'b0;

        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_sum",       64'(sum),       64'd0);
        check("rst_cout",      64'(cout),      64'd0);
        check("rst_err",       64'(err),       64'd0);

        // Case 1 with latency check
        out_ready = 1'b1;
        send(16'h1234, 16'h5678, 1'b0, 1, 0, none);
        repeat (3) step();
        check("lat_out_valid_early", 64'(out_valid), 64'd0);
        check("lat_busy",            64'(busy),      64'd1);
        step();
        check("lat_out_valid", 64'(out_valid), 64'd1);
        check("case1_sum",     64'(sum),       64'h6912);

        // Case 2: carry ripples through every digit
        send(16'h9999, 16'h0000, 1'b1, 1, 0, none);

        // Case 3: held result under back-pressure, extra in_valid ignored
        wait_ready();
        out_ready = 1'b0;
        send(16'h0505, 16'h0505, 1'b0, 1, 0, none);
        repeat (4) step();
        for (int i = 0; i < 10; i++) begin
            if (i >= 2 && i < 5) begin
                in_valid = 1'b1;
                a = 16'h1111;
                b = 16'h2222;
            end else begin
                in_valid = 1'b0;
            end
            check("hold_sum",       64'(sum),       64'h1010);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready",  64'(in_ready),  64'd0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("release_in_ready",  64'(in_ready),  64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);

        // Case 4: reset in the middle of RUN drops the transaction
        send(16'h1234, 16'h1111, 1'b0, 0, 0, none);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sum",       64'(sum),       64'd0);
        check("midrst_cout",      64'(cout),      64'd0);
        send(16'h0001, 16'h0001, 1'b0, 1, 0, none);

        // Case 5: back-to-back accepts with in_valid held high
        wait_ready();
        last_acc = -1;
        for (int n = 0; n < 6; n++) begin
            logic [W-1:0] x, y;
            logic c;
            wait_ready();
            if (last_acc >= 0) check("b2b_period", 64'(cyc - last_acc), 64'(DIGITS + 2));
            last_acc = cyc;
            x = rand_bcd();
            y = rand_bcd();
            c = 1'($urandom_range(0, 1));
            a = x; b = y; cin = c;
            in_valid = 1'b1;
            sb.push_back(model(x, y, c));
            step();
        end
        in_valid = 1'b0;

        // Non-BCD operand digit, then a clean one
        ovr.sum = 16'h0100; ovr.cout = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
        ovr.err = 1'b1;
`else
        ovr.err = 1'b0;
`endif
        send(16'h00A0, 16'h0000, 1'b0, 1, 1, ovr);
        send(16'h0001, 16'h0000, 1'b0, 1, 0, none);

        // Random traffic with random back-pressure
        rnd_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) step();
            send(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1, 0, none);
        end

        for (int i = 0; i < 500 && sb.size() != 0; i++) step();
        rnd_ready = 1'b0;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
